// File: rtl/hazard_controller.sv
// Pipeline hazard unit: stall/flush control, EX/MEM/WB dest tracking, operand forwarding.
// Define HAZARD_FORWARD_EN for forwarding with load-use stalls; default stalls on any hazard.
module hazard_controller #(
    parameter logic [15:0] CNT_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  id_rn,
    input  logic [3:0]  id_rm,
    input  logic [3:0]  id_rd,
    input  logic        id_use_rn,
    input  logic        id_use_rm,
    input  logic        id_use_rd,
    input  logic [3:0]  id_dest,
    input  logic        id_rf_e,
    input  logic        id_load,
    input  logic        ex_branch_taken,
    output logic        enable_pc,
    output logic        enable_ifid,
    output logic        flush_ifid,
    output logic        S,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  fwd_c,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] ex_dest;
    logic [3:0] mem_dest;
    logic [3:0] wb_dest;
    logic       ex_we;
    logic       mem_we;
    logic       wb_we;
    logic       ex_ld;
    logic       mem_ld;
    logic       wb_ld;
    logic [2:0] m_ex;
    logic [2:0] m_mem;
    logic [2:0] m_wb;
    logic       stall;
    logic       branch;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic [1:0] fwd_c_raw;
    logic       unused_ld;

    // R15 is the PC, never a tracked register destination
    function automatic logic hit(
        input logic       en,
        input logic [3:0] src,
        input logic       we,
        input logic [3:0] dest
    );
        return en && we && (src == dest) && (src != 4'hF);
    endfunction

    always_comb begin
        m_ex  = {hit(id_use_rd, id_rd, ex_we, ex_dest),
                 hit(id_use_rm, id_rm, ex_we, ex_dest),
                 hit(id_use_rn, id_rn, ex_we, ex_dest)};
        m_mem = {hit(id_use_rd, id_rd, mem_we, mem_dest),
                 hit(id_use_rm, id_rm, mem_we, mem_dest),
                 hit(id_use_rn, id_rn, mem_we, mem_dest)};
        m_wb  = {hit(id_use_rd, id_rd, wb_we, wb_dest),
                 hit(id_use_rm, id_rm, wb_we, wb_dest),
                 hit(id_use_rn, id_rn, wb_we, wb_dest)};
    end

`ifdef HAZARD_FORWARD_EN
    function automatic logic [1:0] pick(
        input logic e,
        input logic m,
        input logic w
    );
        if (e)      return 2'b01;
        else if (m) return 2'b10;
        else if (w) return 2'b11;
        else        return 2'b00;
    endfunction

    assign stall     = ex_ld && (|m_ex);
    assign fwd_a_raw = pick(m_ex[0], m_mem[0], m_wb[0]);
    assign fwd_b_raw = pick(m_ex[1], m_mem[1], m_wb[1]);
    assign fwd_c_raw = pick(m_ex[2], m_mem[2], m_wb[2]);
`else
    assign stall     = |{m_ex, m_mem, m_wb};
    assign fwd_a_raw = 2'b00;
    assign fwd_b_raw = 2'b00;
    assign fwd_c_raw = 2'b00;
`endif

    assign branch    = ex_branch_taken;
    assign unused_ld = ex_ld ^ mem_ld ^ wb_ld;
    assign fwd_a     = reset ? fwd_a_raw : 2'b00;
    assign fwd_b     = reset ? fwd_b_raw : 2'b00;
    assign fwd_c     = reset ? fwd_c_raw : 2'b00;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_dest  <= 4'd0;
            ex_we    <= 1'b0;
            ex_ld    <= 1'b0;
            mem_dest <= 4'd0;
            mem_we   <= 1'b0;
            mem_ld   <= 1'b0;
            wb_dest  <= 4'd0;
            wb_we    <= 1'b0;
            wb_ld    <= 1'b0;
        end else begin
            mem_dest <= ex_dest;
            mem_we   <= ex_we;
            mem_ld   <= ex_ld;
            wb_dest  <= mem_dest;
            wb_we    <= mem_we;
            wb_ld    <= mem_ld;
            ex_dest  <= id_dest;
            ex_we    <= id_rf_e && !S;
            ex_ld    <= id_load && !S;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= CNT_INIT;
            flush_cnt <= CNT_INIT;
        end else begin
            if (stall && !branch && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (branch && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = RUN;
        unique case (1'b1)
            branch:           state_d = FLUSH;
            stall && !branch: state_d = STALL;
            default:          state_d = RUN;
        endcase
    end

    always_comb begin
        enable_pc   = 1'b1;
        enable_ifid = 1'b1;
        flush_ifid  = 1'b0;
        S           = 1'b0;
        unique case (1'b1)
            !reset: S = 1'b1;
            reset && branch: begin
                flush_ifid = 1'b1;
                S          = 1'b1;
            end
            reset && !branch && stall: begin
                enable_pc   = 1'b0;
                enable_ifid = 1'b0;
                S           = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; follows HAZARD_FORWARD_EN if defined.
module tb_hazard_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  id_rn;
    logic [3:0]  id_rm;
    logic [3:0]  id_rd;
    logic        id_use_rn;
    logic        id_use_rm;
    logic        id_use_rd;
    logic [3:0]  id_dest;
    logic        id_rf_e;
    logic        id_load;
    logic        ex_branch_taken;
    logic        enable_pc;
    logic        enable_ifid;
    logic        flush_ifid;
    logic        S;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [1:0]  fwd_c;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        unused_s_pc;
    logic        unused_s_ifid;
    logic        unused_s_flush;
    logic        unused_s_s;
    logic [1:0]  unused_s_fa;
    logic [1:0]  unused_s_fb;
    logic [1:0]  unused_s_fc;
    logic [1:0]  unused_s_state;
    logic [15:0] sat_stall_cnt;
    logic [15:0] sat_flush_cnt;

    int checks = 0;
    int errors = 0;

`ifdef HAZARD_FORWARD_EN
    localparam logic [15:0] EXP_SCNT = 16'd1;
`else
    localparam logic [15:0] EXP_SCNT = 16'd3;
`endif

    hazard_controller dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .id_dest(id_dest), .id_rf_e(id_rf_e), .id_load(id_load),
        .ex_branch_taken(ex_branch_taken),
        .enable_pc(enable_pc), .enable_ifid(enable_ifid),
        .flush_ifid(flush_ifid), .S(S),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_controller #(.CNT_INIT(16'hFFFF)) dut_sat (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .id_dest(id_dest), .id_rf_e(id_rf_e), .id_load(id_load),
        .ex_branch_taken(ex_branch_taken),
        .enable_pc(unused_s_pc), .enable_ifid(unused_s_ifid),
        .flush_ifid(unused_s_flush), .S(unused_s_s),
        .fwd_a(unused_s_fa), .fwd_b(unused_s_fb), .fwd_c(unused_s_fc),
        .state(unused_s_state),
        .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0;
        id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
        id_dest = 4'd0; id_rf_e = 1'b0; id_load = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic issue(input logic [3:0] d, input logic ld);
        idle();
        id_dest = d;
        id_rf_e = 1'b1;
        id_load = ld;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_pc", 16'(enable_pc), 16'd1);
        chk("rst_ifid", 16'(enable_ifid), 16'd1);
        chk("rst_s", 16'(S), 16'd1);
        ex_branch_taken = 1'b1;
        #1;
        chk("rst_flush", 16'(flush_ifid), 16'd0);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_scnt", stall_cnt, 16'd0);
        ex_branch_taken = 1'b0;
        reset = 1'b1;
        #1;
        chk("run_s", 16'(S), 16'd0);
        chk("run_pc", 16'(enable_pc), 16'd1);
        chk("run_ifid", 16'(enable_ifid), 16'd1);
        tick();
        chk("run_state", 16'(state), 16'd0);
        chk("run_scnt", stall_cnt, 16'd0);
        chk("run_fcnt", flush_cnt, 16'd0);

`ifdef HAZARD_FORWARD_EN
        issue(4'd1, 1'b0);
        tick();
        idle(); id_use_rn = 1'b1; id_rn = 4'd1;
        #1;
        chk("fwd_ex", 16'(fwd_a), 16'd1);
        chk("fwd_ex_pc", 16'(enable_pc), 16'd1);
        chk("fwd_ex_s", 16'(S), 16'd0);
        tick();
        chk("fwd_mem", 16'(fwd_a), 16'd2);
        tick();
        chk("fwd_wb", 16'(fwd_a), 16'd3);
        tick();
        chk("fwd_none", 16'(fwd_a), 16'd0);
        issue(4'd2, 1'b1);
        tick();
        idle(); id_use_rm = 1'b1; id_rm = 4'd2;
        #1;
        chk("lu_pc", 16'(enable_pc), 16'd0);
        chk("lu_ifid", 16'(enable_ifid), 16'd0);
        chk("lu_s", 16'(S), 16'd1);
        tick();
        chk("lu_scnt", stall_cnt, 16'd1);
        chk("lu_state", 16'(state), 16'd1);
        chk("lu_pc_after", 16'(enable_pc), 16'd1);
        chk("lu_fwd_b", 16'(fwd_b), 16'd2);
        chk("lu_sat", sat_stall_cnt, 16'hFFFF);
        tick();
        chk("lu_state_run", 16'(state), 16'd0);
        chk("lu_scnt_hold", stall_cnt, 16'd1);
`else
        issue(4'd3, 1'b0);
        tick();
        idle(); id_use_rd = 1'b1; id_rd = 4'd3; id_dest = 4'd4; id_rf_e = 1'b1;
        #1;
        chk("ns_pc0", 16'(enable_pc), 16'd0);
        chk("ns_s0", 16'(S), 16'd1);
        chk("ns_fwd_c0", 16'(fwd_c), 16'd0);
        tick();
        chk("ns_state1", 16'(state), 16'd1);
        chk("ns_scnt1", stall_cnt, 16'd1);
        chk("ns_pc1", 16'(enable_pc), 16'd0);
        tick();
        chk("ns_scnt2", stall_cnt, 16'd2);
        chk("ns_pc2", 16'(enable_pc), 16'd0);
        tick();
        chk("ns_scnt3", stall_cnt, 16'd3);
        chk("ns_pc3", 16'(enable_pc), 16'd1);
        chk("ns_s3", 16'(S), 16'd0);
        chk("ns_fwd_c3", 16'(fwd_c), 16'd0);
        chk("ns_sat", sat_stall_cnt, 16'hFFFF);
        tick();
        chk("ns_state_run", 16'(state), 16'd0);
        chk("ns_scnt_hold", stall_cnt, 16'd3);
`endif
        idle();
        tick();
        tick();
        tick();

        issue(4'd15, 1'b0);
        tick();
        idle(); id_use_rn = 1'b1; id_rn = 4'd15; id_use_rm = 1'b1; id_rm = 4'd15;
        #1;
        chk("r15_pc", 16'(enable_pc), 16'd1);
        chk("r15_s", 16'(S), 16'd0);
        chk("r15_fwd_a", 16'(fwd_a), 16'd0);
        chk("r15_fwd_b", 16'(fwd_b), 16'd0);

        issue(4'd2, 1'b1);
        tick();
        idle(); id_use_rm = 1'b1; id_rm = 4'd2; ex_branch_taken = 1'b1;
        #1;
        chk("br_flush", 16'(flush_ifid), 16'd1);
        chk("br_pc", 16'(enable_pc), 16'd1);
        chk("br_ifid", 16'(enable_ifid), 16'd1);
        chk("br_s", 16'(S), 16'd1);
        tick();
        chk("br_state", 16'(state), 16'd2);
        chk("br_fcnt", flush_cnt, 16'd1);
        chk("br_scnt", stall_cnt, EXP_SCNT);
        chk("br_sat_fcnt", sat_flush_cnt, 16'hFFFF);
        idle();
        #1;
        chk("br_after_pc", 16'(enable_pc), 16'd1);
        chk("br_after_flush", 16'(flush_ifid), 16'd0);
        tick();
        chk("br_state_run", 16'(state), 16'd0);
        chk("br_fcnt_hold", flush_cnt, 16'd1);

        issue(4'd3, 1'b1);
        tick();
        idle(); id_use_rn = 1'b1; id_rn = 4'd3;
        #1;
        chk("ms_pc", 16'(enable_pc), 16'd0);
        reset = 1'b0;
        #1;
        chk("ms_rst_pc", 16'(enable_pc), 16'd1);
        chk("ms_rst_s", 16'(S), 16'd1);
        chk("ms_rst_fwd", 16'(fwd_a), 16'd0);
        tick();
        chk("ms_state", 16'(state), 16'd0);
        chk("ms_scnt", stall_cnt, 16'd0);
        chk("ms_fcnt", flush_cnt, 16'd0);
        chk("ms_sat", sat_stall_cnt, 16'hFFFF);
        reset = 1'b1;
        #1;
        chk("ms_rel_pc", 16'(enable_pc), 16'd1);
        chk("ms_rel_s", 16'(S), 16'd0);
        tick();
        chk("ms_rel_state", 16'(state), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock (rising edge).
REQ-002 SHALL have: reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have ID-stage inputs:
- id_rn, id_rm, id_rd  in  4 each  source registers.
- id_use_rn, id_use_rm, id_use_rd  in  1 each  source-valid flags.
- id_dest  in  4  destination register.
- id_rf_e  in  1  instruction writes the register file.
- id_load  in  1  instruction is a load.
REQ-004 SHALL have: ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-005 SHALL have outputs:
- enable_pc  out  1  PC load enable.
- enable_ifid  out  1  IF/ID register enable.
- flush_ifid  out  1  clear IF/ID to NOP.
- S  out  1  NOP-select for the control-signal multiplexer; 1 forces all ID control signals to 0.
REQ-006 SHALL have outputs:
- fwd_a, fwd_b, fwd_c  out  2 each  operand sources for Rn/Rm/Rd: 00 register file, 01 EX, 10 MEM, 11 WB.
- state  out  2  00 RUN, 01 STALL, 10 FLUSH.
- stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-007 SHALL keep internal destination tracking for EX, MEM and WB: dest[3:0], we, ld per stage.
REQ-008 Each rising clk SHALL advance MEM<=EX and WB<=MEM. EX SHALL load {id_dest, id_rf_e, id_load} when S=0; when S=1 it SHALL load we=0, ld=0.
REQ-009 A source SHALL match a stage when its use flag=1, stage we=1, stage dest equals the source, and the source is not R15.
REQ-010 Hazard detection, enables, S, flush and fwd outputs SHALL be combinational from current inputs and the tracking registers, with zero-cycle latency.
REQ-011 Stall condition SHALL assert enable_pc=0, enable_ifid=0, S=1 and flush_ifid=0.
REQ-012 ex_branch_taken=1 SHALL assert flush_ifid=1, S=1, enable_pc=1 and enable_ifid=1, and SHALL override any stall in the same cycle.
REQ-013 With neither stall nor branch, outputs SHALL be enable_pc=1, enable_ifid=1, S=0, flush_ifid=0.
REQ-014 The state register SHALL take the next-state value on each rising clk:
- FLUSH if the branch condition holds.
- Else STALL if the stall condition holds.
- Else RUN.
- FLUSH SHALL last exactly one cycle unless ex_branch_taken repeats.
REQ-015 stall_cnt SHALL increment on each clk where the stall condition holds and branch=0. flush_cnt SHALL increment on each clk where branch=1. Both SHALL saturate at 16'hFFFF without wrap.
REQ-016 A stall SHALL persist while the hazard remains; the tracking registers keep advancing, so every hazard clears in at most 3 cycles.

Reset
REQ-017 With reset=0 at a rising clk:
- All tracking we/ld SHALL clear to 0.
- state SHALL be RUN; stall_cnt and flush_cnt SHALL be 0.
REQ-018 While reset=0, outputs SHALL be enable_pc=1, enable_ifid=1, S=1, flush_ifid=0, fwd_*=00. Reset mid-stall SHALL abandon the stall.

Configuration
REQ-019 Macro HAZARD_FORWARD_EN SHALL select the hazard scheme.
REQ-020 With HAZARD_FORWARD_EN defined:
- fwd_* SHALL select the matching stage, with priority EX > MEM > WB, else 00.
- Stall SHALL occur only on a load-use hazard: any source matching EX with ld=1.
- A load-use stall SHALL last exactly 1 cycle.
REQ-021 Without HAZARD_FORWARD_EN:
- fwd_* SHALL be constant 00.
- Stall SHALL occur on any source match in EX, MEM or WB.

Verification
REQ-022 Bench SHALL cover these scenarios:
- Reset held 2 cycles, then released with no hazards -> state=RUN, S=0, enables 1, counters 0.
- FORWARD_EN: ADD R1 in EX, ID uses Rn=R1 -> fwd_a=01, no stall. Next cycle R1 is in MEM -> fwd_a=10.
- FORWARD_EN: load R2 in EX, ID uses Rm=R2 -> exactly 1 cycle of enable_pc=0, S=1, stall_cnt=1. Next cycle fwd_b=10.
- No macro: ADD R3 in EX, ID uses Rd=R3 -> stall 3 cycles, stall_cnt=3, then RUN with fwd_c=00.
- Branch taken coincident with load-use hazard -> flush_ifid=1, enable_pc=1, state=FLUSH next cycle, flush_cnt=1, stall_cnt unchanged.
- Source R15 matching an EX dest of R15 -> no stall, fwd=00. Counter preloaded to 16'hFFFF then stalled -> remains 16'hFFFF.
